// File: rtl/div_pkg.sv
// Shared constants for the iterative 32-bit divider: FSM state codes,
// step count and the divide-by-zero quotient pattern.
package div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int DIV_ITER  = 32;
  localparam int DIV_CNT_W = 6;

  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFFFFFF;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on the {rem, quo} pair.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The shifted remainder can need WIDTH+1 bits; a non-negative trial always fits in WIDTH.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, divisor_mag};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_32_iterative.sv
// Multi-cycle DIV/DIVU unit: sign-strip, 32 restoring steps, sign fix-up,
// then a one-cycle done pulse carrying LO (quotient) and HI (remainder).
module div_32_iterative
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = DIV_ITER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [DIV_CNT_W-1:0] LAST_STEP = DIV_CNT_W'(ITER - 1);

  logic [1:0]           state;
  logic [DIV_CNT_W-1:0] count;
  logic [WIDTH-1:0]     rem_q;
  logic [WIDTH-1:0]     quo_q;
  logic [WIDTH-1:0]     div_mag;
  logic [WIDTH-1:0]     dvd_raw;
  logic                 sign_q;
  logic                 sign_r;
  logic [WIDTH-1:0]     step_rem;
  logic [WIDTH-1:0]     step_quo;
  logic                 dvd_neg;
  logic                 dsr_neg;

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dsr_neg = is_signed & divisor[WIDTH-1];

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem         (rem_q),
    .quo         (quo_q),
    .divisor_mag (div_mag),
    .rem_next    (step_rem),
    .quo_next    (step_quo)
  );

  // Magnitude of the most negative value wraps to itself, which the unsigned datapath handles as-is.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      count       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_mag     <= '0;
      dvd_raw     <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            quo_q   <= dvd_neg ? -dividend : dividend;
            div_mag <= dsr_neg ? -divisor : divisor;
            dvd_raw <= dividend;
            sign_q  <= dvd_neg ^ dsr_neg;
            sign_r  <= dvd_neg;
            rem_q   <= '0;
            count   <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          count <= count + DIV_CNT_W'(1);
          if (count == LAST_STEP) state <= ST_FIX;
        end
        ST_FIX: begin
          if (div_mag == '0) begin
            quotient    <= WIDTH'(DIV_ZERO_QUOT);
            remainder   <= dvd_raw;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= sign_q ? -quo_q : quo_q;
            remainder   <= sign_r ? -rem_q : rem_q;
            div_by_zero <= 1'b0;
          end
          state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_32_iterative.md
Name: div_32_iterative

Overview:
- Multi-cycle 32-bit integer divider for the MIPS execute stage; implements DIV/DIVU and produces the LO (quotient) and HI (remainder) values.
- Counterpart to the single-cycle bitwise ALU units: those are combinational, this block iterates one restoring-division step per clock under a start/done handshake.
- The pipeline stalls on busy and writes HI/LO on done.

Parameters:
WIDTH, 32, operand and result width
ITER, 32, division steps per operation (must equal WIDTH)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only while not busy
is_signed  input  1  1 = DIV (two's complement), 0 = DIVU
dividend  input  WIDTH  numerator, sampled with start
divisor  input  WIDTH  denominator, sampled with start
busy  output  1  operation in progress
done  output  1  one-cycle pulse; results valid
quotient  output  WIDTH  LO value
remainder  output  WIDTH  HI value
div_by_zero  output  1  last completed operation had divisor == 0

Behaviour:
- Reset (synchronous, rst high at a clock edge):
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state=IDLE.
  - Reset wins over every other input, including mid-operation; the operation in flight is discarded and done never pulses for it.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 at edge E0: latch operands and is_signed.
  - If signed, convert each operand to magnitude and record sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend).
  - Clear partial remainder; count=0; go to RUN. busy=1 from the cycle after E0.
- RUN:
  - One restoring step per edge: shift {rem, quo} left 1; trial = rem - divisor_mag (WIDTH+1 bits); if non-negative, rem = trial and quo LSB = 1.
  - count increments each step; after ITER steps (edge E32), go to FIX.
- FIX (edge E33):
  - Negate quotient if sign_q; negate remainder if sign_r.
  - Register the results on quotient/remainder and set div_by_zero; go to DONE.
- DONE:
  - done=1 and busy=1 for exactly this one cycle; next edge returns to IDLE with busy=0.
- Latency: done is high in the cycle between edges E33 and E34. The fixed latency is independent of operand values.
- Outputs quotient, remainder and div_by_zero hold their values from the last completed operation until the next FIX; they are not cleared by a new start.
- start while busy=1 is ignored; it is not queued.
- start in the DONE cycle is ignored. The earliest back-to-back start is the cycle after done.
- Divide by zero:
  - Runs the full latency.
  - Result is quotient=0xFFFFFFFF, remainder=dividend (original, unmodified), div_by_zero=1, regardless of is_signed.
- Signed overflow, 0x80000000 / 0xFFFFFFFF:
  - Quotient=0x80000000, remainder=0. The magnitude path yields this naturally via 32-bit wrap; no special case is needed.
- Signed results:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Invariant for divisor != 0: dividend == quotient*divisor + remainder (mod 2^32).
- Magnitude of 0x80000000 is 0x80000000, treated as unsigned.

Decomposition:
- Shared package div_pkg:
  - State enum (IDLE, RUN, FIX, DONE).
  - Constants DIV_ITER=32 and DIV_CNT_W=6.
  - Constant DIV_ZERO_QUOT=32'hFFFFFFFF.
- Sub-module div_step: purely combinational single restoring step. Inputs rem, quo, divisor_mag; outputs next rem and next quo.

Test Plan:
- Unsigned 100 / 7:
  - start with is_signed=0 -> done 33 edges later, quotient=14, remainder=2, div_by_zero=0.
  - busy high for cycles 1..34.
- Signed -100 / 7 (0xFFFFFF9C / 7):
  - -> quotient=0xFFFFFFF2, remainder=0xFFFFFFFE.
- Signed 100 / -7:
  - -> quotient=0xFFFFFFF2, remainder=2.
- Divide by zero, 0x12345678 / 0:
  - is_signed=0 and is_signed=1 -> quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1, same latency.
- Signed 0x80000000 / 0xFFFFFFFF:
  - -> quotient=0x80000000, remainder=0.
- Unsigned 0xFFFFFFFF / 1:
  - -> quotient=0xFFFFFFFF, remainder=0.
- Handshake and reset:
  - Pulse start again at cycle 10 with different operands -> ignored; first result unchanged.
  - Assert rst at cycle 20 of a new operation -> next cycle busy=0, all outputs 0, no done pulse.
  - New start after reset -> correct result at the normal latency.
